cp0_unit: RTL

- Coprocessor-0 register file and exception controller. It is the responder for the decode stage's CP0 read channel and the commit-side CP0 write channel.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Arbitrates interrupts and exceptions reported by the MEM stage, issues the pipeline flush and supplies the handler or return PC to the fetch stage.

---
 rtl/cp0_unit_pkg.sv | 41 ++++
 rtl/cp0_unit_if.sv | 16 +
 rtl/cp0_unit_timer.sv | 37 +++
 rtl/cp0_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause bit
// positions, writable masks and the default exception vector.
package cp0_unit_pkg;

  localparam logic [31:0] EXC_HANDLER_DEFAULT = 32'hBFC0_0380;
  localparam int unsigned REG_ADDR_W          = 5;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_BP  = 5'd9,
    EXC_OV  = 5'd12
  } exc_code_e;

  localparam int unsigned STATUS_IE     = 0;
  localparam int unsigned STATUS_EXL    = 1;
  localparam int unsigned STATUS_IM_LSB = 8;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_LSB  = 8;
  localparam int unsigned CAUSE_HW_LSB  = 10;
  localparam int unsigned CAUSE_TI      = 15;
  localparam int unsigned CAUSE_BD      = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// CP0 access channel: decode-side read port and commit-side mtc0 write port.
interface cp0_unit_if;
  import cp0_unit_pkg::*;

  logic                  read_en;
  logic [REG_ADDR_W-1:0] read_addr;
  logic [31:0]           read_data;
  logic                  write_en;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [31:0]           write_data;

  modport master (output read_en, read_addr, write_en, write_addr, write_data,
                  input  read_data);
  modport slave  (input  read_en, read_addr, write_en, write_addr, write_data,
                  output read_data);
endinterface

// File: rtl/cp0_unit_timer.sv
// Count/Compare pair with a programmable prescaler; flags Count==Compare.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        hit
);
  logic [31:0] div;
  logic        tick;

  assign tick = (div == COUNT_DIV - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
    end else begin
      div <= tick ? '0 : div + 32'd1;
      if (count_we)
        count <= wdata;
      else if (tick)
        count <= count + 32'd1;
      if (compare_we)
        compare <= wdata;
    end
  end

  // Compare==0 is the disarmed state.
  assign hit = (count == compare) && (compare != '0);
endmodule

// File: rtl/cp0_unit.sv
// CP0 register file and exception controller: arbitrates MEM-stage events,
// raises the pipeline flush and supplies the handler/return PC.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] EXC_HANDLER_ADDR = EXC_HANDLER_DEFAULT,
  parameter int unsigned COUNT_DIV        = 1
) (
  input  logic        clk,
  input  logic        rst,
  cp0_unit_if.slave   bus,
  input  logic [5:0]  hw_int,
  input  logic [31:0] exc_pc,
  input  logic        exc_delayslot,
  input  logic        exc_syscall,
  input  logic        exc_break,
  input  logic        exc_overflow,
  input  logic        exc_eret,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic        timer_int
);
  logic [31:0] status_q, cause_q, epc_q, status_d, cause_d, epc_d;
  logic [31:0] status_wr, cause_wr, count, compare, badvaddr, epc_fwd, rdata;
  logic        timer_hit, int_pending, take, wr, bypass;
  logic        count_we, compare_we;
  exc_code_e   code;
  logic        unused_hw;

  // No address-error sources reach this unit, so BadVAddr holds its reset value.
  assign badvaddr  = '0;
  assign unused_hw = hw_int[5];

  assign int_pending = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                       (|(cause_q[CAUSE_IP_LSB +: 8] & status_q[STATUS_IM_LSB +: 8]));

  always_comb begin
    take = 1'b1;
    code = EXC_INT;
    if (int_pending)       code = EXC_INT;
    else if (exc_syscall)  code = EXC_SYS;
    else if (exc_break)    code = EXC_BP;
    else if (exc_overflow) code = EXC_OV;
    else                   take = 1'b0;
  end

  // A taken exception squashes the committing mtc0; an eret does not.
  assign wr         = bus.write_en & ~take;
  assign count_we   = wr & (bus.write_addr == REG_COUNT);
  assign compare_we = wr & (bus.write_addr == REG_COMPARE);
  assign status_wr  = apply_mask(status_q, bus.write_data, STATUS_WMASK);
  assign cause_wr   = apply_mask(cause_q, bus.write_data, CAUSE_WMASK);
  assign epc_fwd    = (bus.write_en && bus.write_addr == REG_EPC) ? bus.write_data : epc_q;

  assign flush    = ~rst & (take | exc_eret);
  assign flush_pc = take ? EXC_HANDLER_ADDR : epc_fwd;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (bus.write_data),
    .count      (count),
    .compare    (compare),
    .hit        (timer_hit)
  );

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (wr) begin
      case (bus.write_addr)
        REG_STATUS: status_d = status_wr;
        REG_CAUSE:  cause_d  = cause_wr;
        REG_EPC:    epc_d    = bus.write_data;
        default:    ;
      endcase
    end
    cause_d[CAUSE_HW_LSB +: 5] = hw_int[4:0];
    if (compare_we)
      cause_d[CAUSE_TI] = 1'b0;
    else if (timer_hit)
      cause_d[CAUSE_TI] = 1'b1;
    if (take) begin
      status_d[STATUS_EXL]         = 1'b1;
      cause_d[CAUSE_EXC_LSB +: 5] = code;
      if (!status_q[STATUS_EXL]) begin
        cause_d[CAUSE_BD] = exc_delayslot;
        epc_d             = exc_delayslot ? exc_pc - 32'd4 : exc_pc;
      end
    end else if (exc_eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // Same-cycle mtc0 to the register being read returns its post-write value.
  always_comb begin
    bypass = bus.write_en && (bus.write_addr == bus.read_addr);
    case (bus.read_addr)
      REG_BADVADDR: rdata = badvaddr;
      REG_COUNT:    rdata = bypass ? bus.write_data : count;
      REG_COMPARE:  rdata = bypass ? bus.write_data : compare;
      REG_STATUS:   rdata = bypass ? status_wr : status_q;
      REG_CAUSE:    rdata = bypass ? cause_wr : cause_q;
      REG_EPC:      rdata = bypass ? bus.write_data : epc_q;
      default:      rdata = '0;
    endcase
    bus.read_data = bus.read_en ? rdata : '0;
  end

  assign status    = status_q;
  assign cause     = cause_q;
  assign timer_int = cause_q[CAUSE_TI];
endmodule
